mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_if.sv | 30 +++
 rtl/mdu_step.sv | 40 ++++
 rtl/mdu.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: constants, op and state encodings, and the magnitude helper
// shared by the multiply/divide unit and its interface.
package mdu_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Two's-complement magnitude when sgn is set; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return sgn ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the pipeline and the MDU.
//   start/op/a/b  : operation request (a = rd1, b = rd2)
//   hi_we/lo_we/wd: MTHI/MTLO write
//   busy/done     : operation in flight / one-cycle completion pulse
//   hi/lo         : architectural HI/LO registers
interface mdu_if #(parameter int XLEN = mdu_pkg::XLEN);

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wd;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wd,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the MDU datapath.
//   i_div      : 1 = restoring divide step, 0 = shift-add multiply step
//   i_hi, i_lo : working accumulator (MUL: partial product / multiplier,
//                DIV: partial remainder / dividend-quotient)
//   i_m        : multiplicand or divisor magnitude
//   o_hi, o_lo : accumulator after the step
module mdu_step #(parameter int XLEN = 32) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_m,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_sub;
  logic            w_ge;

  always_comb begin
    // MUL: add multiplicand when multiplier LSB is set, then shift the
    // 65-bit {carry, hi, lo} right by one.
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : '0);
    // DIV: shift remainder left pulling in the next dividend bit; the
    // remainder stays below the divisor, so the low XLEN bits of the
    // difference are exact whenever the trial subtraction succeeds.
    w_shift = {i_hi, i_lo[XLEN-1]};
    w_ge    = (w_shift >= {1'b0, i_m});
    w_sub   = w_shift[XLEN-1:0] - i_m;
    if (i_div) begin
      o_hi = w_ge ? w_sub : w_shift[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], w_ge};
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit with architectural HI/LO registers.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mdu_if.slave (request, MTHI/MTLO write, busy/done, hi/lo)
// Latency: 32 RUN iterations on magnitudes, one FIX cycle for signs,
// HI/LO written on the FIX->DONE edge, done high for the DONE cycle.
module mdu #(parameter int XLEN = mdu_pkg::XLEN) (
  input  logic  clk,
  input  logic  rst_n,
  mdu_if.slave  bus
);
  import mdu_pkg::*;

  state_e            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  op_e               r_op;
  logic              r_a_neg, r_b_neg;
  logic [XLEN-1:0]   r_acc_hi, r_acc_lo, r_m;
  logic [XLEN-1:0]   r_hi, r_lo;
  logic [XLEN-1:0]   w_step_hi, w_step_lo, w_res_hi, w_res_lo;
  logic [2*XLEN-1:0] w_prod;
  logic              w_open, w_accept, w_signed, w_div, w_run_div;
  logic              w_busy, w_done;

  assign w_open    = (r_state == IDLE) || (r_state == DONE);
  assign w_accept  = w_open && bus.start;
  assign w_signed  = bus.op[0];
  assign w_div     = bus.op[1];
  assign w_run_div = (r_op == OP_DIVU) || (r_op == OP_DIV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      IDLE: w_next = bus.start ? RUN : IDLE;
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_W'(ITER_COUNT - 1)) w_next = FIX;
      end
      FIX: begin
        w_busy = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = bus.start ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  mdu_step #(.XLEN(XLEN)) u_step (
    .i_div (w_run_div),
    .i_hi  (r_acc_hi),
    .i_lo  (r_acc_lo),
    .i_m   (r_m),
    .o_hi  (w_step_hi),
    .o_lo  (w_step_lo)
  );

  // Operand latch and working accumulator. MUL keeps the multiplier in
  // the low half; DIV keeps the dividend there and shifts quotient bits in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= OP_MULTU;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_m      <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_op     <= op_e'(bus.op);
      r_a_neg  <= w_signed & bus.a[XLEN-1];
      r_b_neg  <= w_signed & bus.b[XLEN-1];
      r_acc_hi <= '0;
      if (w_div) begin
        r_acc_lo <= mag(bus.a, w_signed & bus.a[XLEN-1]);
        r_m      <= mag(bus.b, w_signed & bus.b[XLEN-1]);
      end else begin
        r_acc_lo <= mag(bus.b, w_signed & bus.b[XLEN-1]);
        r_m      <= mag(bus.a, w_signed & bus.a[XLEN-1]);
      end
    end else if (r_state == RUN) begin
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Sign fix-up. Divide by zero still gives remainder = dividend through
  // the normal path (the unsigned step yields |a|, re-signed by a's sign);
  // only the quotient is forced to all ones.
  always_comb begin
    w_prod   = {r_acc_hi, r_acc_lo};
    w_res_hi = '0;
    w_res_lo = '0;
    if (w_run_div) begin
      w_res_lo = (r_a_neg ^ r_b_neg) ? -r_acc_lo : r_acc_lo;
      w_res_hi = r_a_neg ? -r_acc_hi : r_acc_hi;
      if (r_m == '0) w_res_lo = '1;
    end else begin
      if (r_a_neg ^ r_b_neg) w_prod = -w_prod;
      {w_res_hi, w_res_lo} = w_prod;
    end
  end

  // Architectural HI/LO: result on FIX->DONE, MTHI/MTLO only while idle
  // or done (a coincident start still lets the write land).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == FIX) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if (w_open) begin
      if (bus.hi_we) r_hi <= bus.wd;
      if (bus.lo_we) r_lo <= bus.wd;
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
